// File: rtl/data_mem_mmio_responder_pkg.sv
// Shared encodings for the memory-stage responder: access sizes, MMIO register
// offsets and STATUS bit positions.
package data_mem_mmio_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] MMIO_LED    = 5'h00;
  localparam logic [4:0] MMIO_SEG    = 5'h04;
  localparam logic [4:0] MMIO_SW     = 5'h08;
  localparam logic [4:0] MMIO_BTN    = 5'h0C;
  localparam logic [4:0] MMIO_STATUS = 5'h10;

  // One past the last implemented register offset.
  localparam logic [31:0] MMIO_SPAN = 32'h14;

  localparam int ST_MISALIGN = 0;
  localparam int ST_UNMAPPED = 1;

  // Byte enables for a store of the given size at the given byte lane.
  function automatic logic [3:0] store_enables(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_mmio_responder_btn.sv
// Per-button 2-flop synchroniser, rising-edge detector and sticky event bit.
// A rising edge in the same cycle as clr keeps the bit set.
module btn_event_capture #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  input  logic         clr,
  output logic [N-1:0] evt
);

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      evt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      evt   <= (evt & ~{N{clr}}) | (sync2 & ~prev);
    end
  end

endmodule

// File: rtl/data_mem_mmio_responder.sv
// Memory-stage responder: word-organised data RAM plus the game MMIO window.
// Every access completes in the cycle it is presented; loads are combinational.
module data_mem_mmio_responder
  import data_mem_mmio_responder_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          N_BTN     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       func3,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [15:0]      sw_in,
  input  logic [N_BTN-1:0] btn_in,
  output logic [15:0]      led_out,
  output logic [31:0]      seg_out,
  output logic [1:0]       err_out
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0] ram [RAM_WORDS];

  logic [15:0]      led;
  logic [31:0]      seg;
  logic [1:0]       status;
  logic [15:0]      sw_s1;
  logic [15:0]      sw_s2;
  logic [N_BTN-1:0] btn_evt;

  logic        access;
  logic        f3_ok;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        ram_hit;
  logic        mmio_hit;
  logic        ok;
  logic        unmapped;
  logic [31:0] mmio_off;
  logic [AW-1:0] widx;
  logic [31:0] rword;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ram_load;
  logic [31:0] mmio_load;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic        ram_we;
  logic        mmio_we;
  logic        btn_clr;
  logic [1:0]  status_clr;
  logic [1:0]  new_err;

  // Classification order: illegal funct3, then alignment, then address decode.
  always_comb begin
    access  = mem_read | mem_write;
    f3_ok   = (!mem_read  || (func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) &&
              (!mem_write || (func3 inside {F3_B, F3_H, F3_W}));
    is_half = (func3[1:0] == 2'b01);
    is_word = (func3 == F3_W);
    misaligned = access && f3_ok &&
                 ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
    mmio_off = addr - MMIO_BASE;
    ram_hit  = (addr < RAM_BYTES);
    mmio_hit = !ram_hit && is_word && (mmio_off < MMIO_SPAN);
    ok       = access && f3_ok && !misaligned && (ram_hit || mmio_hit);
    unmapped = access && !misaligned && !ok;
    new_err  = {unmapped, misaligned};
  end

  always_comb begin
    widx  = addr[AW+1:2];
    rword = ram[widx];
    case (addr[1:0])
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = addr[1] ? rword[31:16] : rword[15:0];
    case (func3)
      F3_B:    ram_load = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ram_load = {24'b0, byte_sel};
      F3_H:    ram_load = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ram_load = {16'b0, half_sel};
      default: ram_load = rword;
    endcase
  end

  always_comb begin
    case (mmio_off[4:0])
      MMIO_LED:    mmio_load = {16'b0, led};
      MMIO_SEG:    mmio_load = seg;
      MMIO_SW:     mmio_load = {16'b0, sw_s2};
      MMIO_BTN:    mmio_load = 32'(btn_evt);
      MMIO_STATUS: mmio_load = {30'b0, status};
      default:     mmio_load = 32'b0;
    endcase
    if (mem_read && ok) rdata = ram_hit ? ram_load : mmio_load;
    else                rdata = 32'b0;
  end

  always_comb begin
    be = store_enables(func3, addr[1:0]);
    case (func3)
      F3_B:    wlane = {4{wdata[7:0]}};
      F3_H:    wlane = {2{wdata[15:0]}};
      default: wlane = wdata;
    endcase
    ram_we     = mem_write && ok && ram_hit && !rst;
    mmio_we    = mem_write && ok && mmio_hit;
    btn_clr    = mem_read && ok && mmio_hit && (mmio_off[4:0] == MMIO_BTN);
    status_clr = (mmio_we && (mmio_off[4:0] == MMIO_STATUS)) ? wdata[1:0] : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // A new error outranks a write-1-to-clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      led    <= '0;
      seg    <= '0;
      status <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      if (mmio_we && (mmio_off[4:0] == MMIO_LED)) led <= wdata[15:0];
      if (mmio_we && (mmio_off[4:0] == MMIO_SEG)) seg <= wdata;
      status <= (status & ~status_clr) | new_err;
    end
  end

  btn_event_capture #(.N(N_BTN)) u_btn (
    .clk (clk),
    .rst (rst),
    .btn (btn_in),
    .clr (btn_clr),
    .evt (btn_evt)
  );

  assign led_out = led;
  assign seg_out = seg;
  assign err_out = status;

endmodule

// File: tb/tb_data_mem_mmio_responder.sv
// Randomised and directed bench for data_mem_mmio_responder against a
// byte-array / input-history reference model.
module tb_data_mem_mmio_responder;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] sw_in;
  logic [4:0]  btn_in;
  logic [15:0] led_out;
  logic [31:0] seg_out;
  logic [1:0]  err_out;

  always #5 clk = ~clk;

  data_mem_mmio_responder dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .func3     (func3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .sw_in     (sw_in),
    .btn_in    (btn_in),
    .led_out   (led_out),
    .seg_out   (seg_out),
    .err_out   (err_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  m_mem [4096];
  logic [15:0] m_led = '0;
  logic [31:0] m_seg = '0;
  logic [1:0]  m_status = '0;
  logic [4:0]  m_evt = '0;
  logic [15:0] sw_h  [3];
  logic [4:0]  btn_h [3];
  logic [15:0] cur_sw = '0;
  logic [4:0]  cur_btn = '0;

  // Expected rdata from the pre-edge state, then advance the model by one edge.
  // sw_h/btn_h hold the input values seen at the last three edges (index 0 newest).
  task automatic model_step(input bit r, input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [15:0] sw, input logic [4:0] btn,
                            output logic [31:0] er);
    int size;
    bit sgn, mis, unm, hit_ram, hit_io, clr_evt;
    logic [31:0] off, v;
    logic [1:0] clr_st;
    er = '0; mis = 0; unm = 0; hit_ram = 0; hit_io = 0; clr_evt = 0; clr_st = '0;
    size = 0; sgn = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    off = a - MB;
    if (rd || wr) begin
      if (size == 0 || (wr && f3[2]))       unm = 1;
      else if ((a % size) != 0)             mis = 1;
      else if (a < 32'd4096)                hit_ram = 1;
      else if (size == 4 && off <= 32'd16)  hit_io = 1;
      else                                  unm = 1;
    end
    if (rd && hit_ram) begin
      v = '0;
      for (int i = 0; i < size; i++) v |= 32'(m_mem[int'(a) + i]) << (8 * i);
      if (sgn && size == 1 && v[7])  v |= 32'hFFFF_FF00;
      if (sgn && size == 2 && v[15]) v |= 32'hFFFF_0000;
      er = v;
    end
    if (rd && hit_io) begin
      case (off)
        32'd0:   er = {16'b0, m_led};
        32'd4:   er = m_seg;
        32'd8:   er = {16'b0, sw_h[1]};
        32'd12:  begin er = {27'b0, m_evt}; clr_evt = 1; end
        default: er = {30'b0, m_status};
      endcase
    end
    if (r) begin
      m_led = '0; m_seg = '0; m_status = '0; m_evt = '0;
      for (int i = 0; i < 3; i++) begin sw_h[i] = '0; btn_h[i] = '0; end
    end else begin
      if (wr && hit_ram)
        for (int i = 0; i < size; i++) m_mem[int'(a) + i] = wd[8*i +: 8];
      if (wr && hit_io) begin
        if (off == 32'd0)  m_led = wd[15:0];
        if (off == 32'd4)  m_seg = wd;
        if (off == 32'd16) clr_st = wd[1:0];
      end
      m_evt    = (clr_evt ? 5'd0 : m_evt) | (btn_h[1] & ~btn_h[2]);
      m_status = (m_status & ~clr_st) | {unm, mis};
      sw_h[2] = sw_h[1];   sw_h[1] = sw_h[0];   sw_h[0] = sw;
      btn_h[2] = btn_h[1]; btn_h[1] = btn_h[0]; btn_h[0] = btn;
    end
  endtask

  // One access cycle: drive at negedge, sample rdata mid-low phase, check
  // registered outputs just after the rising edge.
  task automatic tick(input bit r, input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] er;
    @(negedge clk);
    rst = r; mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
    sw_in = cur_sw; btn_in = cur_btn;
    #1 got = rdata;
    model_step(r, rd, wr, f3, a, wd, cur_sw, cur_btn, er);
    check("rdata", got, er);
    @(posedge clk);
    #1;
    check("led", {16'b0, led_out}, {16'b0, m_led});
    check("seg", seg_out, m_seg);
    check("err", {30'b0, err_out}, {30'b0, m_status});
  endtask

  task automatic idle(output logic [31:0] got);
    tick(0, 0, 0, 3'd0, 32'd0, 32'd0, got);
  endtask

  logic [31:0] got;
  logic [31:0] keep20;

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; func3 = 0; addr = 0; wdata = 0;
    sw_in = 0; btn_in = 0;
    for (int i = 0; i < 3; i++) begin sw_h[i] = '0; btn_h[i] = '0; end

    tick(1, 0, 0, 3'd0, 32'd0, 32'd0, got);
    tick(1, 0, 0, 3'd0, 32'd0, 32'd0, got);
    check("reset_led", {16'b0, led_out}, 32'd0);
    check("reset_status", {30'b0, err_out}, 32'd0);

    for (int w = 0; w < 64; w++) tick(0, 0, 1, 3'd2, 32'(w * 4), $urandom, got);

    // Sizing and extension
    tick(0, 0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, got);
    tick(0, 1, 0, 3'd2, 32'h10, 32'd0, got);  check("lw_10", got, 32'hDEAD_BEEF);
    tick(0, 1, 0, 3'd0, 32'h13, 32'd0, got);  check("lb_13", got, 32'hFFFF_FFDE);
    tick(0, 1, 0, 3'd4, 32'h13, 32'd0, got);  check("lbu_13", got, 32'h0000_00DE);
    tick(0, 1, 0, 3'd1, 32'h10, 32'd0, got);  check("lh_10", got, 32'hFFFF_BEEF);
    tick(0, 0, 1, 3'd0, 32'h11, 32'h55, got);
    tick(0, 1, 0, 3'd2, 32'h10, 32'd0, got);  check("lw_after_sb", got, 32'hDEAD_55EF);

    // Errors and write-1-to-clear
    tick(0, 1, 0, 3'd2, 32'h12, 32'd0, got);  check("lw_misaligned", got, 32'd0);
    check("status_mis", {30'b0, err_out}, 32'd1);
    tick(0, 0, 1, 3'd2, 32'h12, 32'hFFFF_FFFF, got);
    tick(0, 1, 0, 3'd2, 32'h10, 32'd0, got);  check("ram_unchanged", got, 32'hDEAD_55EF);
    tick(0, 0, 1, 3'd2, MB + 32'h10, 32'h1, got);
    check("status_clr", {30'b0, err_out}, 32'd0);
    tick(0, 1, 0, 3'd2, 32'h4000_0000, 32'd0, got);
    check("status_unm", {30'b0, err_out}, 32'd2);
    tick(0, 1, 0, 3'd2, MB + 32'h10, 32'd0, got); check("status_read", got, 32'd2);
    tick(0, 0, 1, 3'd2, MB + 32'h10, 32'h3, got);
    tick(0, 1, 1, 3'd2, 32'h10, 32'h0102_0304, got); check("rw_prewrite", got, 32'hDEAD_55EF);

    // LED, SEG, switches
    tick(0, 0, 1, 3'd2, MB, 32'h0000_A5A5, got);
    check("led_a5a5", {16'b0, led_out}, 32'h0000_A5A5);
    tick(0, 0, 1, 3'd2, MB + 32'h4, 32'h1234_5678, got);
    tick(0, 1, 0, 3'd0, MB, 32'd0, got);     check("mmio_byte_unm", got, 32'd0);
    cur_sw = 16'h0F0F;
    repeat (3) idle(got);
    tick(0, 1, 0, 3'd2, MB + 32'h8, 32'd0, got); check("sw_read", got, 32'h0000_0F0F);

    // Button events
    cur_btn = 5'b00100;
    idle(got);
    cur_btn = 5'b00000;
    idle(got);
    idle(got);
    tick(0, 1, 0, 3'd2, MB + 32'hC, 32'd0, got); check("btn2_evt", got, 32'h4);
    tick(0, 1, 0, 3'd2, MB + 32'hC, 32'd0, got); check("btn_cleared", got, 32'h0);
    cur_btn = 5'b00001;
    idle(got);
    idle(got);
    tick(0, 1, 0, 3'd2, MB + 32'hC, 32'd0, got); check("btn_clear_cycle", got, 32'h0);
    tick(0, 1, 0, 3'd2, MB + 32'hC, 32'd0, got); check("btn_set_wins", got, 32'h1);
    cur_btn = 5'b00000;

    // Reset in the middle of a store
    tick(0, 1, 0, 3'd2, 32'h4000_0000, 32'd0, got);
    cur_btn = 5'b00010;
    repeat (3) idle(got);
    tick(0, 1, 0, 3'd2, 32'h20, 32'd0, got);
    keep20 = got;
    tick(1, 0, 1, 3'd2, 32'h20, 32'h1234_5678, got);
    check("rst_led", {16'b0, led_out}, 32'd0);
    check("rst_seg", seg_out, 32'd0);
    check("rst_status", {30'b0, err_out}, 32'd0);
    cur_btn = 5'b00000;
    tick(0, 1, 0, 3'd2, MB + 32'hC, 32'd0, got); check("rst_btn_evt", got, 32'd0);
    tick(0, 1, 0, 3'd2, 32'h20, 32'd0, got);     check("rst_no_write", got, keep20);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [31:0] a;
      logic [2:0] f3;
      bit rd, wr, r;
      sel = $urandom_range(0, 99);
      f3  = 3'($urandom_range(0, 7));
      rd  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 3) == 0);
      if (sel < 60)      a = 32'($urandom_range(0, 255));
      else if (sel < 85) a = MB + 32'($urandom_range(0, 31));
      else               a = {2'b01, 30'($urandom)};
      if ($urandom_range(0, 9) == 0)  cur_btn = 5'($urandom);
      if ($urandom_range(0, 19) == 0) cur_sw = 16'($urandom);
      r = ($urandom_range(0, 49) == 0);
      tick(r, rd, wr, f3, a, $urandom, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
